cdc_event_sender: RTL

- Source-domain controller that sequences a 2-phase toggle request/acknowledge channel to a destination clock domain.
- Local 1-cycle event pulses are counted and launched one at a time as req toggles. The next event launches only after the destination's ack toggle is synchronized back and matches.
- Sits between local event producers and the destination-side toggle synchronizer pair. This makes event transfer lossless up to the counter depth.

---
 rtl/cdc_pkg.sv | 18 +
 rtl/cdc_sync_chain.sv | 43 ++++
 rtl/cdc_event_sender.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/cdc_pkg.sv
// -----------------------------------------------------------------------------
// cdc_pkg
// Shared definitions for the toggle-handshake event sender and its synchronizer.
//   state_e          : sender FSM states (ERROR is only reachable when the
//                      CDC_TIMEOUT_EN watchdog is built in)
//   MIN_SYNC_STAGES  : smallest legal synchronizer depth
// -----------------------------------------------------------------------------
package cdc_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    ERROR    = 2'd2
  } state_e;

  localparam int MIN_SYNC_STAGES = 2;

endpackage : cdc_pkg

// File: rtl/cdc_sync_chain.sv
// -----------------------------------------------------------------------------
// cdc_sync_chain
// STAGES-deep flop synchronizer for a single asynchronous level, with clock
// enable and synchronous active-high reset. Used for the ack toggle here and
// for the matching req toggle on the destination side.
// Ports:
//   clk   in  capturing-domain clock
//   rst   in  synchronous active-high reset (clears every stage)
//   i_en  in  clock enable; all stages hold while low
//   i_d   in  asynchronous input level
//   o_q   out synchronized level (last stage)
// -----------------------------------------------------------------------------
module cdc_sync_chain
  import cdc_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_d,
  output logic o_q
);

  if (STAGES < MIN_SYNC_STAGES) begin : g_bad_stages
    $error("cdc_sync_chain: STAGES must be at least MIN_SYNC_STAGES");
  end

  logic [STAGES-1:0] r_sync;

  // NOTE: every synchronizer stage is reset so the toggle level restarts at 0
  // on both sides; a stale 1 left in the chain would look like a pending ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
    end else if (i_en) begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule : cdc_sync_chain

// File: rtl/cdc_event_sender.sv
// -----------------------------------------------------------------------------
// cdc_event_sender
// Source-domain side of a 2-phase toggle req/ack channel. Local 1-cycle event
// pulses are queued in a saturating counter and launched one at a time as
// req_toggle inversions; the next launch waits until the synchronized ack
// level equals req_toggle again.
//
// Optional build macro: CDC_TIMEOUT_EN
//   Adds a TIMEOUT_W-bit watchdog over WAIT_ACK; on expiry timeout_err sets
//   and the FSM parks in ERROR until reset. Without it timeout_err is 0.
//
// Ports:
//   clk               in  source-domain clock
//   rst               in  synchronous active-high reset
//   enable            in  clock enable; all state (incl. ack sync) holds when low
//   event_in          in  1-cycle event pulse from local logic
//   ack_toggle_async  in  ack toggle from the destination domain (async)
//   req_toggle        out request toggle to the destination domain
//   busy              out high while a launched event awaits its ack
//   pending_count     out events accepted but not yet launched
//   sent              out 1-cycle pulse per acknowledged event
//   overflow          out sticky: an event was dropped at a full counter
//   timeout_err       out sticky watchdog expiry flag
// -----------------------------------------------------------------------------
module cdc_event_sender
  import cdc_pkg::*;
#(
  parameter int CNT_W       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             event_in,
  input  logic             ack_toggle_async,
  output logic             req_toggle,
  output logic             busy,
  output logic [CNT_W-1:0] pending_count,
  output logic             sent,
  output logic             overflow,
  output logic             timeout_err
);

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("cdc_event_sender: CNT_W must be at least 1");
  end
  if (TIMEOUT_W < 1) begin : g_bad_timeout_w
    $error("cdc_event_sender: TIMEOUT_W must be at least 1");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           r_state;
  logic             r_req_toggle;
  logic             r_busy;
  logic [CNT_W-1:0] r_pending;
  logic             r_sent;
  logic             r_overflow;

  logic             w_ack_sync;
  logic             w_match;
  logic             w_has_pending;

`ifdef CDC_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] WD_ONE  = {{(TIMEOUT_W-1){1'b0}}, 1'b1};
  localparam logic [TIMEOUT_W-1:0] WD_LAST = {TIMEOUT_W{1'b1}} - WD_ONE;

  logic [TIMEOUT_W-1:0] r_wd;
  logic                 r_timeout_err;
`endif

  cdc_sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk  (clk),
    .rst  (rst),
    .i_en (enable),
    .i_d  (ack_toggle_async),
    .o_q  (w_ack_sync)
  );

  // The destination echoes req back as ack, so equal levels mean the last
  // launched event has been taken.
  assign w_match       = (w_ack_sync == r_req_toggle);
  assign w_has_pending = (r_pending != '0);

  // NOTE: all sequential state uses non-blocking assignments so every branch
  // below reads the pre-edge values of r_pending / r_req_toggle consistently.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_req_toggle <= 1'b0;
      r_busy       <= 1'b0;
      r_pending    <= '0;
      r_sent       <= 1'b0;
      r_overflow   <= 1'b0;
`ifdef CDC_TIMEOUT_EN
      r_wd          <= '0;
      r_timeout_err <= 1'b0;
`endif
    end else if (enable) begin
      r_sent <= 1'b0;
      case (r_state)
        IDLE: begin
          // Queued events go first; a same-edge event_in then takes the freed
          // slot, so the count is unchanged. With nothing queued, event_in is
          // launched directly and never counted.
          if (w_has_pending || event_in) begin
            r_req_toggle <= ~r_req_toggle;
            r_state      <= WAIT_ACK;
            r_busy       <= 1'b1;
            if (w_has_pending && !event_in) begin
              r_pending <= r_pending - CNT_ONE;
            end
`ifdef CDC_TIMEOUT_EN
            r_wd <= '0;
`endif
          end
        end

        WAIT_ACK: begin
          if (w_match) begin
            r_sent <= 1'b1;
            // Relaunch on the same edge if anything is queued, counting the
            // event_in arriving now; +1 and -1 cancel, so a full counter
            // never drops an event on a match edge.
            if (w_has_pending || event_in) begin
              r_req_toggle <= ~r_req_toggle;
              if (!event_in) begin
                r_pending <= r_pending - CNT_ONE;
              end
`ifdef CDC_TIMEOUT_EN
              r_wd <= '0;
`endif
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            if (event_in) begin
              if (r_pending == CNT_MAX) begin
                r_overflow <= 1'b1;
              end else begin
                r_pending <= r_pending + CNT_ONE;
              end
            end
`ifdef CDC_TIMEOUT_EN
            // Expiry on the edge that would bring the count to all-ones.
            if (r_wd == WD_LAST) begin
              r_timeout_err <= 1'b1;
              r_state       <= ERROR;
              r_busy        <= 1'b0;
            end else begin
              r_wd <= r_wd + WD_ONE;
            end
`endif
          end
        end

`ifdef CDC_TIMEOUT_EN
        ERROR: begin
          // Parked until reset: req level, counter and flags are frozen.
        end
`endif

        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end else begin
      // sent is an event pulse, not held state: it must not stretch while
      // the clock enable is low.
      r_sent <= 1'b0;
    end
  end

  assign req_toggle    = r_req_toggle;
  assign busy          = r_busy;
  assign pending_count = r_pending;
  assign sent          = r_sent;
  assign overflow      = r_overflow;

`ifdef CDC_TIMEOUT_EN
  assign timeout_err = r_timeout_err;
`else
  assign timeout_err = 1'b0;
`endif

endmodule : cdc_event_sender
